// File: rtl/hazard_sequencer_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer: FSM states,
// pipeline-register bit indices and canonical write/clear vectors.
package hazard_sequencer_pkg;

  typedef enum logic [1:0] {
    SEQ_RUN      = 2'b00,
    SEQ_MEM_WAIT = 2'b01,
    SEQ_HALT     = 2'b10,
    SEQ_RSVD     = 2'b11
  } seq_state_e;

  localparam int PIPE_IFID  = 0;
  localparam int PIPE_IDEX  = 1;
  localparam int PIPE_EXMEM = 2;
  localparam int PIPE_MEMWB = 3;

  localparam logic [3:0] PIPE_WR_ALL     = 4'b1111;
  localparam logic [3:0] PIPE_WR_NONE    = 4'b0000;
  localparam logic [3:0] PIPE_WR_LOADUSE = PIPE_WR_ALL & ~4'(1 << PIPE_IFID);

  localparam logic [3:0] CLR_NONE    = 4'b0000;
  localparam logic [3:0] CLR_ALL     = 4'b1111;
  localparam logic [3:0] CLR_BRANCH  = 4'(1 << PIPE_IFID) | 4'(1 << PIPE_IDEX) | 4'(1 << PIPE_EXMEM);
  localparam logic [3:0] CLR_LOADUSE = 4'(1 << PIPE_IDEX);
  localparam logic [3:0] CLR_FREEZE  = 4'(1 << PIPE_MEMWB);

  typedef struct packed {
    logic       pc_write;
    logic [3:0] pipe_write;
    logic [3:0] pipe_clear;
  } seq_ctrl_t;

  function automatic seq_ctrl_t mk_ctrl(input logic pc, input logic [3:0] wr, input logic [3:0] clr);
    seq_ctrl_t c;
    c.pc_write   = pc;
    c.pipe_write = wr;
    c.pipe_clear = clr;
    return c;
  endfunction

endpackage

// File: rtl/hazard_sequencer_load_use_detect.sv
// Load-use comparator: the load in EX targets a register the ID instruction reads.
// Writes to $zero are never real dependencies.
module load_use_detect
  import hazard_sequencer_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_memr,
  input  logic [4:0] ex_dest,
  output logic       hit
);

  logic rs_match;
  logic rt_match;

  always_comb begin
    rs_match = (ex_dest == id_rs);
    rt_match = id_uses_rt && (ex_dest == id_rt);
    hit      = ex_memr && (ex_dest != 5'd0) && (rs_match || rt_match);
  end

endmodule

// File: rtl/hazard_sequencer.sv
// Central stall/flush sequencer for the 5-stage pipeline (FSM, wait counter, output mux).
// Optional performance counters are compiled in with `HAZ_PERF_CNT_EN.
module hazard_sequencer
  import hazard_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
`ifdef HAZ_PERF_CNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memr,
  input  logic [4:0]       ex_dest,
  input  logic             m_branch_tkn,
  input  logic             m_mem_access,
  input  logic             dmem_busy,
`ifdef HAZ_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt_total,
`endif
  output logic             pc_write,
  output logic [3:0]       pipe_write,
  output logic [3:0]       pipe_clear,
  output logic [1:0]       seq_state,
  output logic             timeout_err
);

  localparam int WCW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

  seq_state_e     state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           timeout_err_q, timeout_err_d;

  logic      lu_hit;
  logic      freeze;
  seq_ctrl_t ctrl;
  logic      ev_stall, ev_flush, ev_freeze;

  load_use_detect u_lud (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .ex_memr    (ex_memr),
    .ex_dest    (ex_dest),
    .hit        (lu_hit)
  );

  assign freeze = m_mem_access && dmem_busy;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= SEQ_RUN;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // wait_cnt counts busy cycles already spent frozen, including the one that left RUN
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      SEQ_HALT: ;
      SEQ_MEM_WAIT: begin
        if (freeze) begin
          if (wait_cnt_q == WAIT_LAST) begin
            state_d       = SEQ_HALT;
            timeout_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WCW'(1);
          end
        end else begin
          state_d    = SEQ_RUN;
          wait_cnt_d = '0;
        end
      end
      default: begin
        if (freeze) begin
          state_d    = SEQ_MEM_WAIT;
          wait_cnt_d = WCW'(1);
        end else begin
          state_d    = SEQ_RUN;
          wait_cnt_d = '0;
        end
      end
    endcase
  end

  always_comb begin
    ctrl      = mk_ctrl(1'b1, PIPE_WR_ALL, CLR_NONE);
    ev_stall  = 1'b0;
    ev_flush  = 1'b0;
    ev_freeze = 1'b0;
    if (reset) begin
      ctrl = mk_ctrl(1'b0, PIPE_WR_NONE, CLR_ALL);
    end else if (state_q == SEQ_HALT) begin
      ctrl = mk_ctrl(1'b0, PIPE_WR_NONE, CLR_NONE);
    end else if (freeze) begin
      ctrl      = mk_ctrl(1'b0, PIPE_WR_NONE, CLR_FREEZE);
      ev_freeze = 1'b1;
    end else if (m_branch_tkn) begin
      ctrl     = mk_ctrl(1'b1, PIPE_WR_ALL, CLR_BRANCH);
      ev_flush = 1'b1;
    end else if (lu_hit) begin
      ctrl     = mk_ctrl(1'b0, PIPE_WR_LOADUSE, CLR_LOADUSE);
      ev_stall = 1'b1;
    end
  end

  assign pc_write    = ctrl.pc_write;
  assign pipe_write  = ctrl.pipe_write;
  assign pipe_clear  = ctrl.pipe_clear;
  assign seq_state   = reset ? SEQ_RUN : state_q;
  assign timeout_err = timeout_err_q && !reset;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] wait_tot_q, wait_tot_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    wait_tot_d  = wait_tot_q;
    if (ev_stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (ev_flush && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    if (ev_freeze && !(&wait_tot_q)) wait_tot_d = wait_tot_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_tot_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      wait_tot_q  <= wait_tot_d;
    end
  end

  assign stall_cnt      = reset ? '0 : stall_cnt_q;
  assign flush_cnt      = reset ? '0 : flush_cnt_q;
  assign wait_cnt_total = reset ? '0 : wait_tot_q;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed plus randomized bench for hazard_sequencer against a rule-level reference model.
module tb_hazard_sequencer;

  localparam int TO    = 4;
  localparam int CNT_W = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_dest;
  logic       id_uses_rt, ex_memr, m_branch_tkn, m_mem_access, dmem_busy;
  logic       pc_write, timeout_err;
  logic [3:0] pipe_write, pipe_clear;
  logic [1:0] seq_state;
`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt_total;
`endif

  always #5 clock = ~clock;

  hazard_sequencer #(.MEM_TIMEOUT(TO)) dut (
    .clock        (clock),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_memr      (ex_memr),
    .ex_dest      (ex_dest),
    .m_branch_tkn (m_branch_tkn),
    .m_mem_access (m_mem_access),
    .dmem_busy    (dmem_busy),
`ifdef HAZ_PERF_CNT_EN
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt),
    .wait_cnt_total (wait_cnt_total),
`endif
    .pc_write     (pc_write),
    .pipe_write   (pipe_write),
    .pipe_clear   (pipe_clear),
    .seq_state    (seq_state),
    .timeout_err  (timeout_err)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference model: consecutive frozen cycles, halted flag, sticky error, event counts
  int busy_run = 0;
  bit halted = 0;
  bit err = 0;
  int n_stall = 0, n_flush = 0, n_freeze = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input bit rst, input bit [4:0] rs, input bit [4:0] rt, input bit urt,
                     input bit memr, input bit [4:0] dst, input bit br, input bit acc, input bit busy);
    bit lu, fr;
    bit e_pc;
    bit [3:0] e_wr, e_clr;
    reset = rst; id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_memr = memr;
    ex_dest = dst; m_branch_tkn = br; m_mem_access = acc; dmem_busy = busy;
    #1;
    lu = memr && dst != 0 && (dst == rs || (urt && dst == rt));
    fr = acc && busy;
    if (rst)         begin e_pc = 0; e_wr = 4'b0000; e_clr = 4'b1111; end
    else if (halted) begin e_pc = 0; e_wr = 4'b0000; e_clr = 4'b0000; end
    else if (fr)     begin e_pc = 0; e_wr = 4'b0000; e_clr = 4'b1000; end
    else if (br)     begin e_pc = 1; e_wr = 4'b1111; e_clr = 4'b0111; end
    else if (lu)     begin e_pc = 0; e_wr = 4'b1110; e_clr = 4'b0010; end
    else             begin e_pc = 1; e_wr = 4'b1111; e_clr = 4'b0000; end
    chk("pc_write", 32'(pc_write), 32'(e_pc));
    chk("pipe_write", 32'(pipe_write), 32'(e_wr));
    chk("pipe_clear", 32'(pipe_clear), 32'(e_clr));
    chk("seq_state", 32'(seq_state), rst ? 32'd0 : halted ? 32'd2 : (busy_run > 0) ? 32'd1 : 32'd0);
    chk("timeout_err", 32'(timeout_err), 32'(err && !rst));
`ifdef HAZ_PERF_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), rst ? 32'd0 : 32'(n_stall));
    chk("flush_cnt", 32'(flush_cnt), rst ? 32'd0 : 32'(n_flush));
    chk("wait_cnt_total", 32'(wait_cnt_total), rst ? 32'd0 : 32'(n_freeze));
`endif
    @(posedge clock);
    if (rst) begin
      busy_run = 0; halted = 0; err = 0; n_stall = 0; n_flush = 0; n_freeze = 0;
    end else if (!halted) begin
      if (fr) begin
        busy_run++;
        if (n_freeze < CMAX) n_freeze++;
        if (busy_run == TO) begin halted = 1; err = 1; end
      end else begin
        busy_run = 0;
        if (br) begin if (n_flush < CMAX) n_flush++; end
        else if (lu) begin if (n_stall < CMAX) n_stall++; end
      end
    end
    #1;
  endtask

  task automatic idle();
    cyc(0, 5'd1, 5'd2, 1, 0, 5'd3, 0, 0, 0);
  endtask

  initial begin
    bit [4:0] regs [4];
    bit hr;
    regs[0] = 5'd0; regs[1] = 5'd8; regs[2] = 5'd9; regs[3] = 5'd17;

    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // load-use, then the load has moved on
    cyc(0, 5'd8, 5'd0, 0, 1, 5'd8, 0, 0, 0);
    idle();
    // no false stall: $zero destination, rt not read
    cyc(0, 5'd0, 5'd4, 1, 1, 5'd0, 0, 0, 0);
    cyc(0, 5'd3, 5'd9, 0, 1, 5'd9, 0, 0, 0);
    cyc(0, 5'd3, 5'd9, 1, 1, 5'd9, 0, 0, 0);
    // branch beats load-use
    cyc(0, 5'd8, 5'd0, 0, 1, 5'd8, 1, 0, 0);
    idle();
    // three-cycle memory wait, freeze beats branch and load-use
    cyc(0, 5'd8, 5'd0, 0, 1, 5'd8, 1, 1, 1);
    cyc(0, 5'd8, 5'd0, 0, 1, 5'd8, 1, 1, 1);
    cyc(0, 5'd8, 5'd0, 0, 1, 5'd8, 0, 1, 1);
    cyc(0, 5'd8, 5'd0, 0, 1, 5'd8, 0, 1, 0);
    idle();
    // timeout into HALT, then reset out of it
    for (int i = 0; i < TO; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc(0, 5'd8, 5'd0, 0, 1, 5'd8, 1, 0, 0);
    cyc(0, 5'd8, 5'd0, 0, 1, 5'd8, 0, 1, 1);
    idle();
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1);
    idle();
    // reset in the middle of a wait
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1);
    idle();
    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      hr = ($urandom_range(0, 99) < 3) || (halted && $urandom_range(0, 99) < 25);
      cyc(hr, regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)], 1'($urandom),
          ($urandom_range(0, 99) < 60), regs[$urandom_range(0, 3)],
          ($urandom_range(0, 99) < 20), 1'($urandom), ($urandom_range(0, 99) < 45));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
